frame_scheduler: RTL

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

---
 rtl/frame_scheduler_pkg.sv | 21 ++
 rtl/frame_scheduler_tick_divider.sv | 25 ++
 rtl/frame_scheduler.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/frame_scheduler_pkg.sv
// Shared game package: frame phase encoding and scheduler constants.
// Used by the scheduler, render and debug logic.
package frame_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        MOVE      = 3'd2,
        COLLIDE   = 3'd3,
        SCROLL    = 3'd4,
        RENDER    = 3'd5,
        OVER      = 3'd6
    } phase_t;

    localparam logic [7:0] OVERRUN_MAX = 8'd255;

    function automatic logic isRunning(input phase_t p);
        return (p >= WAIT_TICK) && (p <= RENDER);
    endfunction

endpackage

// File: rtl/frame_scheduler_tick_divider.sv
// Physics tick divider: pulses tick once every TICK_DIV enabled cycles.
// Counter holds while enable is low.
module tick_divider #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    logic [15:0] count;

    assign tick = enable && (count == 16'(TICK_DIV - 1));

    // Count while enabled, wrapping to zero on the tick cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + 16'd1;
        end
    end

endmodule

// File: rtl/frame_scheduler.sv
// Game frame scheduler: sequences move/collide/scroll/render per tick.
// Optional phase watchdog enabled by defining FRAME_SCHED_WDOG_EN.
module frame_scheduler
    import frame_scheduler_pkg::*;
#(
    parameter int TICK_DIV    = 1,
    parameter int WDOG_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic        move_done,
    input  logic        coll_done,
    input  logic        coll_hit,
    input  logic [31:0] doodle_y,
    input  logic [31:0] min_y,
    input  logic        min_y_crossed,
    input  logic        scroll_done,
    input  logic        render_done,
    output logic        move_go,
    output logic        coll_go,
    output logic        scroll_go,
    output logic        render_go,
    output logic        running,
    output logic        game_over,
    output logic [2:0]  phase,
    output logic [7:0]  overrun_cnt,
    output logic        wdog_err
);

    phase_t     state;
    phase_t     nextState;
    logic [3:0] goReg;
    logic [3:0] goNext;
    logic       tick;
    logic       doneAcc;
    logic       restart;
    logic       wdogFire;

    // Divider is held cleared whenever the game is not running.
    tick_divider #(
        .TICK_DIV(TICK_DIV)
    ) uTick (
        .clk   (clk),
        .reset (reset || !running),
        .enable(running),
        .tick  (tick)
    );

    assign move_go   = goReg[0];
    assign coll_go   = goReg[1];
    assign scroll_go = goReg[2];
    assign render_go = goReg[3];
    assign phase     = state;
    assign restart   = ((state == IDLE) || (state == OVER)) && start;

    // Accept a done only after the go cycle of the current phase.
    always_comb begin
        doneAcc = 1'b0;
        unique case (state)
            MOVE:    doneAcc = move_done && !move_go;
            COLLIDE: doneAcc = coll_done && !coll_go;
            SCROLL:  doneAcc = scroll_done && !scroll_go;
            RENDER:  doneAcc = render_done && !render_go;
            default: doneAcc = 1'b0;
        endcase
    end

`ifdef FRAME_SCHED_WDOG_EN
    logic [31:0] wdogCnt;
    logic        inPhase;
    logic        wdogErr;

    assign inPhase  = (state >= MOVE) && (state <= RENDER);
    assign wdogFire = inPhase && !doneAcc
                   && (wdogCnt == 32'(WDOG_CYCLES - 1));
    assign wdog_err = wdogErr;

    // Per-phase cycle counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdogCnt <= '0;
            wdogErr <= 1'b0;
        end else begin
            if (!inPhase || (nextState != state)) begin
                wdogCnt <= '0;
            end else begin
                wdogCnt <= wdogCnt + 32'd1;
            end
            if (restart) begin
                wdogErr <= 1'b0;
            end else if (wdogFire) begin
                wdogErr <= 1'b1;
            end
        end
    end
`else
    assign wdogFire = 1'b0;
    assign wdog_err = 1'b0;
`endif

    // State, go pulses and overrun counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            goReg       <= '0;
            overrun_cnt <= '0;
        end else begin
            state <= nextState;
            goReg <= goNext;
            if (restart) begin
                overrun_cnt <= '0;
            end else if (tick && (state != WAIT_TICK)
                         && (overrun_cnt != OVERRUN_MAX)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end
    end

    // Next phase from tick, done handshakes and watchdog.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (start) nextState = WAIT_TICK;
            end
            WAIT_TICK: begin
                if (tick && !pause) nextState = MOVE;
            end
            MOVE: begin
                if (doneAcc) nextState = COLLIDE;
                else if (wdogFire) nextState = RENDER;
            end
            COLLIDE: begin
                if (doneAcc) begin
                    if (!coll_hit && (doodle_y < min_y)) nextState = OVER;
                    else if (min_y_crossed) nextState = SCROLL;
                    else nextState = RENDER;
                end else if (wdogFire) begin
                    nextState = RENDER;
                end
            end
            SCROLL: begin
                if (doneAcc || wdogFire) nextState = RENDER;
            end
            RENDER: begin
                if (doneAcc || wdogFire) nextState = WAIT_TICK;
            end
            OVER: begin
                if (start) nextState = WAIT_TICK;
            end
            default: nextState = IDLE;
        endcase
    end

    // Status outputs and go pulses for the phase being entered.
    always_comb begin
        running   = isRunning(state);
        game_over = (state == OVER);
        goNext    = '0;
        goNext[0] = (nextState == MOVE)    && (state != MOVE);
        goNext[1] = (nextState == COLLIDE) && (state != COLLIDE);
        goNext[2] = (nextState == SCROLL)  && (state != SCROLL);
        goNext[3] = (nextState == RENDER)  && (state != RENDER);
    end

endmodule
